// File: rtl/obi_mem_arb_pkg.sv
// Shared types and helpers for the OBI memory round-robin arbiter.
// Imported by obi_mem_arb_fifo and obi_mem_rr_arbiter.
package obi_mem_arb_pkg;

  localparam int OBI_MEM_ARB_MAX_MSTR = 8;

  // Index width with a floor of one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_addr_phase_t;

endpackage

// File: rtl/obi_mem_arb_fifo.sv
// In-order FIFO of master indices for response routing.
// Asynchronous active-low reset; pointers wrap at DEPTH.
module obi_mem_arb_fifo
  import obi_mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage, written on push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/obi_mem_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave between NUM_MSTR masters.
// Optional stall counter: define OBI_MEM_ARB_STALL_CNT_EN.
module obi_mem_rr_arbiter
  import obi_mem_arb_pkg::*;
#(
  parameter int NUM_MSTR        = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_MSTR-1:0]        m_req,
  output logic [NUM_MSTR-1:0]        m_gnt,
  input  logic [NUM_MSTR*ADDR_W-1:0] m_addr,
  input  logic [NUM_MSTR-1:0]        m_we,
  input  logic [NUM_MSTR*DATA_W/8-1:0] m_be,
  input  logic [NUM_MSTR*DATA_W-1:0] m_wdata,
  output logic [NUM_MSTR-1:0]        m_rvalid,
  input  logic [NUM_MSTR-1:0]        m_rready,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_err,
  output logic                       s_req,
  input  logic                       s_gnt,
  output logic [ADDR_W-1:0]          s_addr,
  output logic                       s_we,
  output logic [DATA_W/8-1:0]        s_be,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic                       s_rvalid,
  output logic                       s_rready,
  input  logic [DATA_W-1:0]          s_rdata,
  input  logic                       s_err,
  output logic                       proto_err,
  output logic [31:0]                stall_cnt
);

  localparam int IW   = idx_w(NUM_MSTR);
  localparam int BE_W = DATA_W / 8;

  if (NUM_MSTR < 2 || NUM_MSTR > OBI_MEM_ARB_MAX_MSTR) begin : g_bad_cfg
    $error("obi_mem_rr_arbiter: NUM_MSTR out of range");
  end

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_idx;
  logic          lock_vld;
  logic [IW-1:0] lock_idx;
  logic [IW-1:0] win;
  logic [IW-1:0] head;
  logic          full;
  logic          empty;
  logic          hs;
  logic          pop;

  // Round-robin search upward from the priority pointer
  always_comb begin
    int j;
    logic hit;
    j      = 0;
    hit    = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      j = (int'(rr_ptr) + i) % NUM_MSTR;
      if (!hit && m_req[IW'(j)]) begin
        hit    = 1'b1;
        rr_idx = IW'(j);
      end
    end
  end

  assign win   = lock_vld ? lock_idx : rr_idx;
  assign s_req = reset_n & (|m_req) & ~full;
  assign hs    = s_req & s_gnt;

  // Address-phase mux and grant decode
  always_comb begin
    s_addr  = '0;
    s_we    = 1'b0;
    s_be    = '0;
    s_wdata = '0;
    m_gnt   = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      if (IW'(i) == win) begin
        s_addr  = m_addr[i*ADDR_W +: ADDR_W];
        s_we    = m_we[i];
        s_be    = m_be[i*BE_W +: BE_W];
        s_wdata = m_wdata[i*DATA_W +: DATA_W];
        m_gnt[i] = hs;
      end
    end
  end

  // Response routing to the oldest outstanding master
  always_comb begin
    m_rvalid = '0;
    s_rready = reset_n;
    for (int i = 0; i < NUM_MSTR; i++) begin
      if (!empty && IW'(i) == head) begin
        m_rvalid[i] = s_rvalid;
        s_rready    = m_rready[i];
      end
    end
  end

  assign m_rdata = s_rdata;
  assign m_err   = s_err;
  assign pop     = s_rvalid & s_rready & ~empty;

  // Priority pointer, stall lock and protocol error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      lock_vld  <= 1'b0;
      lock_idx  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr   <= (win == IW'(NUM_MSTR - 1)) ? '0 : win + 1'b1;
        lock_vld <= 1'b0;
      end else if (s_req) begin
        lock_vld <= 1'b1;
        lock_idx <= win;
      end
      if (s_rvalid && empty) proto_err <= 1'b1;
    end
  end

  obi_mem_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (hs),
    .pop     (pop),
    .din     (win),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

`ifdef OBI_MEM_ARB_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles with a request but no handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if ((|m_req) && !hs && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/obi_mem_rr_arbiter.md
Name: obi_mem_rr_arbiter

Overview:
- Shares one OBI memory slave port between NUM_MSTR OBI masters, for example the instruction and data ports of a core model driving one shared memory agent.
- Arbitrates the address phase with round-robin priority.
- Records the winning master of each accepted transaction in an in-order FIFO and routes the response phase back to that master.
- Sits between the master-side and slave-side uvma_obi_memory_if instances in the OBI self-test environment.

Parameters:
- NUM_MSTR, 2, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_OUTSTANDING, 4, maximum accepted transactions without a response (power of 2, ≥ 1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- m_req  in  NUM_MSTR  per-master address-phase request.
- m_gnt  out  NUM_MSTR  per-master grant.
- m_addr  in  NUM_MSTR*ADDR_W  packed per-master address.
- m_we  in  NUM_MSTR  per-master write enable.
- m_be  in  NUM_MSTR*DATA_W/8  per-master byte enables.
- m_wdata  in  NUM_MSTR*DATA_W  per-master write data.
- m_rvalid  out  NUM_MSTR  per-master response valid.
- m_rready  in  NUM_MSTR  per-master response ready.
- m_rdata  out  DATA_W  response data, broadcast to all masters.
- m_err  out  1  response error, broadcast to all masters.
- s_req  out  1  slave request.
- s_gnt  in  1  slave grant.
- s_addr  out  ADDR_W  slave address.
- s_we  out  1  slave write enable.
- s_be  out  DATA_W/8  slave byte enables.
- s_wdata  out  DATA_W  slave write data.
- s_rvalid  in  1  slave response valid.
- s_rready  out  1  slave response ready.
- s_rdata  in  DATA_W  slave response data.
- s_err  in  1  slave response error.
- proto_err  out  1  sticky flag: response received with no outstanding transaction.
- stall_cnt  out  32  arbitration stall-cycle count (optional feature).

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - priority pointer = 0, lock cleared, FIFO empty, proto_err = 0, stall_cnt = 0.
  - Outputs follow combinationally: s_req = 0, m_gnt = 0, m_rvalid = 0, s_rready = 0.
- Selection:
  - The winner is the first m_req set, searching upward from the priority pointer with wrap (index NUM_MSTR-1 → 0).
- Address phase is combinational, zero latency:
  - s_req = any m_req AND NOT fifo_full.
  - s_addr, s_we, s_be and s_wdata are muxed from the winner.
  - m_gnt[winner] = s_gnt AND s_req; all other m_gnt bits are 0.
- Lock:
  - If s_req = 1 and s_gnt = 0, the current winner is registered as locked.
  - Selection stays on the locked master until s_req & s_gnt, so the slave sees stable req and address per OBI.
  - The lock clears on that handshake.
- On handshake (s_req & s_gnt):
  - Push the winner index into the FIFO.
  - Priority pointer := (winner + 1) mod NUM_MSTR.
- FIFO full (count == MAX_OUTSTANDING):
  - s_req = 0 and m_gnt = 0, even if a pop happens in the same cycle; the next cycle proceeds normally.
  - An unlocked winner may change while full.
  - A locked winner cannot occur while full: a push only happens when not full, and a lock is only set while s_req = 1.
- Response phase is combinational:
  - head = FIFO head index.
  - m_rvalid[head] = s_rvalid AND NOT fifo_empty; all other bits are 0.
  - s_rready = m_rready[head] when not empty, else 1 (drain).
  - m_rdata = s_rdata and m_err = s_err, broadcast to all masters.
  - Pop on s_rvalid & s_rready & NOT empty.
- Simultaneous push and pop:
  - Count is unchanged; the pushed entry follows the popped entry in order.
  - Allowed even when count == MAX_OUTSTANDING-1.
- s_rvalid while the FIFO is empty:
  - No m_rvalid asserted.
  - proto_err := 1, sticky until reset.
- Masters with m_req = 0 never receive m_gnt.
- Count width is $clog2(MAX_OUTSTANDING+1); pointer and index widths are $clog2 with a minimum of 1.

Optional Feature:
- Macro: OBI_MEM_ARB_STALL_CNT_EN.
- With the macro defined:
  - stall_cnt increments each cycle where any m_req = 1 and no handshake occurs.
  - The counter is 32-bit and saturates at 0xFFFF_FFFF.
  - It is cleared only by reset.
- Without the macro: stall_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package obi_mem_arb_pkg holds:
  - the localparam function idx_w(n) = max(1, $clog2(n));
  - typedef obi_addr_phase_t, a struct of addr/we/be/wdata with default widths;
  - constant OBI_MEM_ARB_MAX_MSTR = 8.
- One sub-module is natural: obi_mem_arb_fifo.
  - A synchronous in-order FIFO of master indices with push, pop, full, empty and head outputs.
  - Asynchronous active-low reset.
  - Instantiated once.

Test Plan:
- Reset mid-transfer: with 2 outstanding, drop reset_n → s_req/m_gnt/m_rvalid = 0 immediately; the FIFO is empty after release.
- Round-robin fairness: NUM_MSTR=2, both masters hold m_req with s_gnt=1 continuously for 4 cycles → grants alternate m0, m1, m0, m1; responses route back in the same order.
- Lock on stall: m0 requests with s_gnt=0 for 3 cycles while m1 raises m_req in cycle 2 → s_addr stays at m0's address (0x1000); m0 is granted on the first s_gnt; m1 wins next.
- Full FIFO: MAX_OUTSTANDING=4, 4 handshakes with no response → 5th request sees s_req=0 and m_gnt=0; after one response pop, s_req=1 the following cycle.
- Backpressure: head=m1, m_rready[1]=0, s_rvalid=1 with rdata 0xDEADBEEF → s_rready=0, m_rvalid=2'b10 held; pop occurs only after m_rready[1]=1.
- Spurious response: s_rvalid=1 with the FIFO empty → m_rvalid=0, s_rready=1, proto_err=1 from the next cycle onward; with OBI_MEM_ARB_STALL_CNT_EN, 3 blocked-request cycles → stall_cnt=3.
